im_vga_sched: RTL
=================

# im_vga_sched

Display-side controller for the image memory core. Generates 640x480@60 VGA raster timing from the system clock, drives the memory's pixel address (`im_pixel_x`/`im_pixel_y`) and image select (`im_isel`), and realigns the returned `im_rgb` with delayed sync signals. Image-select changes, whether written by the CPU or from an automatic slideshow, take effect only at frame boundaries, so a frame never mixes two images. Sits between the swreg file and the image memory core, and drives the VGA pins.

## Interface
- `CLK_DIV`, 4: clk cycles per pixel; ≥1.
- `ISEL_W`, 8: image-select width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `isel_req` in ISEL_W: CPU-requested image index.
- `isel_wr` in 1: 1-clk pulse; latch `isel_req` as pending.
- `auto_en` in 1: slideshow enable (level).
- `auto_frames` in 8: frames per image in slideshow; 0 treated as 1.
- `img_count` in ISEL_W: number of images; 0 treated as 2^ISEL_W.
- `im_rgb` in 12: pixel data from image memory.
- `im_pixel_x` out 10: column address (hcnt).
- `im_pixel_y` out 10: row address (vcnt).
- `im_isel` out ISEL_W: active image select.
- `vga_rgb` out 12: output pixel, blanked to 0 outside the active area.
- `vga_hs`, `vga_vs` out 1 each: syncs, active-low.
- `frame_start` out 1: 1-clk pulse at each frame wrap.
- `isel_pend` out 1: a CPU write is waiting for a boundary.

## Operation
- Prescaler `div` counts 0..CLK_DIV-1. `tick` = (div==CLK_DIV-1), combinational. With CLK_DIV=1, `tick` is constantly 1.
- On `tick`:
  - `hcnt` counts 0..799, then wraps.
  - `vcnt` increments when `hcnt` wraps; it counts 0..524, then wraps.
  - `im_pixel_x` = `hcnt` and `im_pixel_y` = `vcnt` (registers, no clamping).
- Raster signals, derived from the current counters:
  - active = hcnt<640 && vcnt<480.
  - hs_n = 0 iff 656≤hcnt<752.
  - vs_n = 0 iff 490≤vcnt<492.
- Output stage, registered on `tick`:
  - `vga_hs` ← hs_n, `vga_vs` ← vs_n.
  - `vga_rgb` ← active ? `im_rgb` : 0.
  - Result: output lags address by exactly one pixel tick.
- Boundary event B = `tick` && hcnt==799 && vcnt==524. On the same edge the counters go to (0,0) and `frame_start` pulses high for one clk.
- `isel_wr` handling:
  - Without B on the same edge: `pending` ← `isel_req`, `isel_pend` ← 1.
  - A later write before B overwrites `pending`; last write wins.
- At B, highest priority first:
  1. `isel_wr` on the same edge: `im_isel` ← `isel_req` (bypass); `isel_pend` stays 0; `fcnt` ← 0.
  2. Else `isel_pend`: `im_isel` ← `pending`; `isel_pend` ← 0; `fcnt` ← 0.
  3. Else `auto_en`:
     - If `fcnt`==max(auto_frames,1)-1: `fcnt` ← 0 and `im_isel` advances. The next index is `im_isel`+1, wrapping to 0 when it equals the effective `img_count` (ISEL_W-bit natural wrap when `img_count`=0).
     - Otherwise `fcnt`++.
- `auto_en`=0 clears `fcnt` to 0 on every clk.
- If `im_isel` ≥ `img_count` while auto-advancing, the next index is 0.
- `im_isel` never changes except at B.
- Reset values: div, hcnt, vcnt, `im_pixel_x`, `im_pixel_y`, `im_isel`, pending, `isel_pend`, fcnt, `vga_rgb`, `frame_start` all = 0; `vga_hs`, `vga_vs` = 1.
- Reset mid-frame: immediate return to the reset state. The pending write is lost. The raster restarts at (0,0) on the first tick after release.

## Timing
- Address → `vga_rgb` latency: one tick = CLK_DIV clks.
- Memory requirement: `im_rgb` must be stable at the clk edge CLK_DIV cycles after the address changes, i.e. ≤ CLK_DIV-1 registered read stages (1 stage with the default CLK_DIV=4).
- `im_isel` changes on the same edge that addresses (0,0), so the first pixel of the frame uses the new image.
- Line = 800 ticks; frame = 420000 ticks.
- `vga_hs` low for 96 ticks per line; `vga_vs` low for 1600 ticks per frame.
- `isel_wr` → `im_isel` latency: from 1 clk (write on the B edge) up to one full frame.
- `frame_start` high exactly 1 clk per frame, regardless of CLK_DIV.

## Test plan
- Reset: during reset, outputs are at reset values (`vga_hs`=`vga_vs`=1, `im_isel`=0). After release, the first `frame_start` occurs 420000·CLK_DIV clks later.
- Raster timing:
  - `vga_hs` falls 657 ticks after release (hcnt 656 registered) and stays low 96 ticks; period 3200 clks at CLK_DIV=4.
  - `vga_vs` low for 2 lines.
  - `vga_rgb`=0 whenever hcnt≥640 (delayed by one tick), with `im_rgb` forced to 12'hFFF.
- Deferred select:
  - `isel_wr` with `isel_req`=5 mid-frame → `isel_pend`=1 and `im_isel` stays 0 until B; at B `im_isel`=5 and `isel_pend`=0.
  - Writes of 3 then 7 in one frame → `im_isel`=7 at B.
- Bypass: `isel_wr`=1 with `isel_req`=9 on the B edge → `im_isel`=9 that same edge; `isel_pend` never asserts.
- Slideshow: `auto_en`=1, `auto_frames`=2, `img_count`=3 → `im_isel` per frame 0,0,1,1,2,2,0. A CPU write of 2 mid-sequence takes priority at the next B and restarts the 2-frame count.
- Reset mid-frame: assert `rst` at vcnt=200 with `isel_pend`=1 → `isel_pend`=0, `im_isel`=0, and counters restart at 0 after release.

Source files
------------

// File: rtl/im_vga_sched.sv
// VGA raster generator and image-select scheduler for the image memory core.
// Image-select changes (CPU or slideshow) are applied only at the frame wrap.
module im_vga_sched #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned ISEL_W  = 8,
   parameter int unsigned H_ACT   = 640,
   parameter int unsigned H_FP    = 16,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BP    = 48,
   parameter int unsigned V_ACT   = 480,
   parameter int unsigned V_FP    = 10,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BP    = 33
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ISEL_W-1:0] isel_req,
   input  logic              isel_wr,
   input  logic              auto_en,
   input  logic [7:0]        auto_frames,
   input  logic [ISEL_W-1:0] img_count,
   input  logic [11:0]       im_rgb,
   output logic [9:0]        im_pixel_x,
   output logic [9:0]        im_pixel_y,
   output logic [ISEL_W-1:0] im_isel,
   output logic [11:0]       vga_rgb,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              frame_start,
   output logic              isel_pend
);

   localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG = H_ACT + H_FP;
   localparam int unsigned HS_END = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG = V_ACT + V_FP;
   localparam int unsigned VS_END = VS_BEG + V_SYNC;
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW1    = ISEL_W + 1;

   logic [DIV_W-1:0]  div;
   logic [9:0]        hcnt;
   logic [9:0]        vcnt;
   logic [ISEL_W-1:0] pending;
   logic [7:0]        fcnt;

   logic              tick;
   logic              h_last;
   logic              v_last;
   logic              bnd;
   logic              active;
   logic              hs_n;
   logic              vs_n;
   logic              fr_last;
   logic [IW1-1:0]    isel_inc;
   logic [ISEL_W-1:0] isel_next;

   assign im_pixel_x = hcnt;
   assign im_pixel_y = vcnt;

   // Raster decode from the current (pre-update) counters
   always_comb begin
      tick   = (div == DIV_W'(CLK_DIV - 1));
      h_last = (hcnt == 10'(H_TOT - 1));
      v_last = (vcnt == 10'(V_TOT - 1));
      bnd    = tick && h_last && v_last;
      active = (hcnt < 10'(H_ACT)) && (vcnt < 10'(V_ACT));
      hs_n   = !((hcnt >= 10'(HS_BEG)) && (hcnt < 10'(HS_END)));
      vs_n   = !((vcnt >= 10'(VS_BEG)) && (vcnt < 10'(VS_END)));
   end

   // Slideshow step: frame budget (0 acts as 1) and wrapped next index
   always_comb begin
      fr_last  = (auto_frames == 8'd0) ? (fcnt == 8'd0) : (fcnt == auto_frames - 8'd1);
      isel_inc = {1'b0, im_isel} + IW1'(1);
      if (img_count == '0) begin
         isel_next = isel_inc[ISEL_W-1:0];
      end else if (isel_inc >= {1'b0, img_count}) begin
         isel_next = '0;
      end else begin
         isel_next = isel_inc[ISEL_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div         <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         im_isel     <= '0;
         pending     <= '0;
         isel_pend   <= 1'b0;
         fcnt        <= '0;
         vga_rgb     <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         div         <= tick ? '0 : div + DIV_W'(1);

         if (tick) begin
            hcnt    <= h_last ? '0 : hcnt + 10'd1;
            if (h_last) vcnt <= v_last ? '0 : vcnt + 10'd1;
            vga_hs  <= hs_n;
            vga_vs  <= vs_n;
            vga_rgb <= active ? im_rgb : 12'd0;
         end

         // Select updates happen only on the frame wrap; CPU beats slideshow
         if (bnd) begin
            frame_start <= 1'b1;
            if (isel_wr) begin
               im_isel   <= isel_req;
               isel_pend <= 1'b0;
               fcnt      <= '0;
            end else if (isel_pend) begin
               im_isel   <= pending;
               isel_pend <= 1'b0;
               fcnt      <= '0;
            end else if (auto_en) begin
               if (fr_last) begin
                  fcnt    <= '0;
                  im_isel <= isel_next;
               end else begin
                  fcnt <= fcnt + 8'd1;
               end
            end
         end else if (isel_wr) begin
            pending   <= isel_req;
            isel_pend <= 1'b1;
         end

         if (!auto_en) fcnt <= '0;
      end
   end

endmodule
